// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
//
// Read-side controller for a circular-queue FIFO. A start command requests a
// burst of len words; the controller pops them from the FIFO and forwards them
// downstream on a valid/ready stream through a 2-entry in-order output buffer.
// done pulses for one cycle once the last word has been accepted downstream.
// abort stops further popping, but words already buffered are still delivered.
//
// Parameters
//   DATA_WIDTH   width of FIFO words and out_data
//   LEN_WIDTH    width of burst length (max burst 2**LEN_WIDTH-1 words)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   start        1-cycle burst request, sampled only in IDLE
//   len          burst length, sampled with start
//   abort        stop popping (honoured only in READ)
//   fifo_empty   FIFO empty flag
//   fifo_r_data  FIFO head word, valid whenever fifo_empty=0
//   fifo_rd      FIFO pop strobe (combinational)
//   out_valid    out_data holds a valid word
//   out_ready    consumer accepts the word when out_valid && out_ready
//   out_data     buffer head word (0 when the buffer is empty)
//   busy         controller is not IDLE
//   done         1-cycle pulse at the end of a burst
//   words_left   words still to pop in the current burst
// -----------------------------------------------------------------------------
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  abort,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  fifo_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  words_left
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [LEN_WIDTH-1:0] len_zero = '0;
  localparam logic [LEN_WIDTH-1:0] len_one  = LEN_WIDTH'(1);

  state_t                 state, state_next;
  logic [LEN_WIDTH-1:0]   words_left_next;

  // Output buffer: two entries, 1-bit pointers, occupancy 0..2.
  logic [DATA_WIDTH-1:0]  buf_mem [2];
  logic                   buf_wr_ptr;
  logic                   buf_rd_ptr;
  logic [1:0]             buf_cnt;

  logic                   push;
  logic                   pop;

  // ---------------------------------------------------------------------------
  // Pop strobe and stream handshake
  // ---------------------------------------------------------------------------
  // The pop looks only at the current occupancy: a full buffer does not pop
  // even if the consumer drains a word in the same cycle. This keeps fifo_rd
  // independent of out_ready; with out_ready held high the buffer never
  // exceeds one word, so throughput is still one word per cycle.
  assign fifo_rd = (state == S_READ) && !abort && !fifo_empty &&
                   (words_left != len_zero) && (buf_cnt < 2'd2);

  assign push      = fifo_rd;
  assign out_valid = (buf_cnt != 2'd0);
  assign pop       = out_valid && out_ready;

  // Gated so out_data reads 0 whenever nothing is buffered, including reset.
  assign out_data  = out_valid ? buf_mem[buf_rd_ptr] : '0;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // ---------------------------------------------------------------------------
  // Buffer storage
  // ---------------------------------------------------------------------------
  // NOTE: the data entries carry no reset; out_valid (from buf_cnt) qualifies
  // them, so resetting the storage would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_mem[buf_wr_ptr] <= fifo_r_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_wr_ptr <= 1'b0;
      buf_rd_ptr <= 1'b0;
      buf_cnt    <= 2'd0;
    end else begin
      if (push) begin
        buf_wr_ptr <= ~buf_wr_ptr;
      end
      if (pop) begin
        buf_rd_ptr <= ~buf_rd_ptr;
      end
      unique case ({push, pop})
        2'b10:   buf_cnt <= buf_cnt + 2'd1;
        2'b01:   buf_cnt <= buf_cnt - 2'd1;
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values; the combinational block below uses blocking ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      words_left <= len_zero;
    end else begin
      state      <= state_next;
      words_left <= words_left_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next state and burst counter
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    state_next      = state;
    words_left_next = words_left;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (len == len_zero) begin
            state_next = S_DONE;
          end else begin
            state_next      = S_READ;
            words_left_next = len;
          end
        end
      end

      S_READ: begin
        if (abort) begin
          state_next      = S_DRAIN;
          words_left_next = len_zero;
        end else if (words_left == len_zero) begin
          state_next = S_DRAIN;
        end else if (fifo_rd) begin
          words_left_next = words_left - len_one;
          if (words_left == len_one) begin
            state_next = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        // Finish once nothing remains after this edge.
        if ((buf_cnt == 2'd0) || ((buf_cnt == 2'd1) && pop)) begin
          state_next = S_DONE;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_burst_reader
//
// Bench for fifo_burst_reader. A small FIFO model feeds the DUT; a monitor logs
// pops, downstream transfers and done pulses. A cycle-by-cycle vector table
// covers a plain burst and the zero-length burst; hand-written sequences cover
// back-pressure, empty FIFO, abort and reset mid-burst.
// -----------------------------------------------------------------------------
module tb_fifo_burst_reader;

  localparam int DW = 8;
  localparam int LW = 4;

  logic          clk;
  logic          reset;
  logic          start;
  logic [LW-1:0] len;
  logic          abort;
  logic          fifo_empty;
  logic [DW-1:0] fifo_r_data;
  logic          fifo_rd;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;
  logic [LW-1:0] words_left;

  fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .len         (len),
    .abort       (abort),
    .fifo_empty  (fifo_empty),
    .fifo_r_data (fifo_r_data),
    .fifo_rd     (fifo_rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .done        (done),
    .words_left  (words_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: written by the stimulus, popped by the monitor.
  logic [DW-1:0] fifo_mem [16];
  int            wr_count = 0;
  int            rd_count = 0;

  assign fifo_empty  = (wr_count == rd_count);
  assign fifo_r_data = fifo_mem[rd_count[3:0]];

  // Monitor
  logic [DW-1:0] xfer_log [64];
  int            xfer_count      = 0;
  int            done_count      = 0;
  int            empty_pop_count = 0;

  always @(posedge clk) begin
    if (fifo_rd) begin
      rd_count <= rd_count + 1;
      if (fifo_empty) empty_pop_count <= empty_pop_count + 1;
    end
    if (out_valid && out_ready) begin
      xfer_log[xfer_count[5:0]] <= out_data;
      xfer_count <= xfer_count + 1;
    end
    if (done) done_count <= done_count + 1;
  end

  int vec_count  = 0;
  int miss_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    fifo_mem[wr_count[3:0]] = d;
    wr_count++;
  endtask

  // Waits (bounded) until a cycle with done=1; returns at negedge+1 of it.
  task automatic wait_done(input string name, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, 32'(found), 32'd1);
  endtask

  typedef struct {
    logic          start;
    logic [LW-1:0] len;
    logic          out_ready;
    logic          exp_rd;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic          exp_busy;
    logic          exp_done;
    logic [LW-1:0] exp_left;
  } vec_t;

  vec_t vecs [11];

  int base_rd;
  int base_xfer;
  int base_done;
  logic found;

  initial begin
    // Burst of 3 from a FIFO holding 5,8,12, then a zero-length burst whose
    // DONE cycle carries a start that must be ignored.
    vecs[0]  = '{1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 4'd0};
    vecs[1]  = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 8'd0,  1'b1, 1'b0, 4'd3};
    vecs[2]  = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 8'd5,  1'b1, 1'b0, 4'd2};
    vecs[3]  = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 8'd8,  1'b1, 1'b0, 4'd1};
    vecs[4]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 8'd12, 1'b1, 1'b0, 4'd0};
    vecs[5]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 4'd0};
    vecs[6]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 4'd0};
    vecs[7]  = '{1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 4'd0};
    vecs[8]  = '{1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 4'd0};
    vecs[9]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 4'd0};
    vecs[10] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 4'd0};

    reset     = 1'b0;
    start     = 1'b0;
    len       = '0;
    abort     = 1'b0;
    out_ready = 1'b0;
    push_word(8'd5);
    push_word(8'd8);
    push_word(8'd12);

    // Reset state, with a start pending and a non-empty FIFO.
    start = 1'b1;
    len   = 4'd3;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", {16'd0, fifo_rd, out_valid, out_data, busy, done, words_left}, 32'd0);
    check("reset_no_pop", 32'(rd_count), 32'd0);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // ---- Table-driven: plain burst and zero-length burst ----
    base_xfer = xfer_count;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      start     = vecs[i].start;
      len       = vecs[i].len;
      out_ready = vecs[i].out_ready;
      #1;
      check($sformatf("vec%0d", i),
            {16'd0, fifo_rd, out_valid, out_data, busy, done, words_left},
            {16'd0, vecs[i].exp_rd, vecs[i].exp_valid, vecs[i].exp_data,
             vecs[i].exp_busy, vecs[i].exp_done, vecs[i].exp_left});
    end
    check("t1_order", {8'd0, xfer_log[base_xfer], xfer_log[base_xfer+1], xfer_log[base_xfer+2]},
          {8'd0, 8'd5, 8'd8, 8'd12});

    // ---- Back-pressure: len=4 with out_ready=0 ----
    push_word(8'd2);
    push_word(8'd9);
    push_word(8'd14);
    push_word(8'd13);
    base_rd   = rd_count;
    base_xfer = xfer_count;
    base_done = done_count;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b1;
    len       = 4'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("t2_pops_stalled", 32'(rd_count - base_rd), 32'd2);
    check("t2_rd_low", {31'd0, fifo_rd}, 32'd0);
    check("t2_head_held", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'd2});
    check("t2_left", 32'(words_left), 32'd2);
    out_ready = 1'b1;
    wait_done("t2", 20);
    @(negedge clk);
    #1;
    check("t2_order", {xfer_log[base_xfer], xfer_log[base_xfer+1], xfer_log[base_xfer+2],
          xfer_log[base_xfer+3]}, {8'd2, 8'd9, 8'd14, 8'd13});
    check("t2_xfers", 32'(xfer_count - base_xfer), 32'd4);
    check("t2_single_done", 32'(done_count - base_done), 32'd1);
    check("t2_idle", {30'd0, busy, done}, 32'd0);

    // ---- Empty FIFO: len=2, words arrive later ----
    base_rd   = rd_count;
    base_xfer = xfer_count;
    start = 1'b1;
    len   = 4'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("t3_wait_state", {15'd0, fifo_rd, busy, 11'd0, words_left}, {15'd0, 1'b0, 1'b1, 11'd0, 4'd2});
    @(negedge clk);
    push_word(8'd6);
    #1;
    check("t3_pop6", {31'd0, fifo_rd}, 32'd1);
    @(negedge clk);
    #1;
    check("t3_after6", {22'd0, fifo_rd, out_valid, out_data}, {22'd0, 1'b0, 1'b1, 8'd6});
    @(negedge clk);
    push_word(8'd7);
    wait_done("t3", 20);
    check("t3_order", {16'd0, xfer_log[base_xfer], xfer_log[base_xfer+1]}, {16'd0, 8'd6, 8'd7});
    check("t3_pops", 32'(rd_count - base_rd), 32'd2);

    // ---- Abort after 3 pops of an 8-word burst ----
    for (int i = 0; i < 8; i++) push_word(8'(20 + i));
    base_rd   = rd_count;
    base_xfer = xfer_count;
    @(negedge clk);
    start = 1'b1;
    len   = 4'd8;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (rd_count - base_rd == 3) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("t5_three_pops", 32'(found), 32'd1);
    abort = 1'b1;
    #1;
    check("t5_abort_suppresses", {31'd0, fifo_rd}, 32'd0);
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("t5_after_abort", {27'd0, fifo_rd, words_left}, 32'd0);
    wait_done("t5", 20);
    check("t5_pops", 32'(rd_count - base_rd), 32'd3);
    check("t5_order", {8'd0, xfer_log[base_xfer], xfer_log[base_xfer+1], xfer_log[base_xfer+2]},
          {8'd0, 8'd20, 8'd21, 8'd22});
    check("t5_fifo_left", 32'(wr_count - rd_count), 32'd5);

    // ---- Reset mid-burst with two words buffered ----
    base_rd = rd_count;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b1;
    len       = 4'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("t6_buffered", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'd23});
    check("t6_pops", 32'(rd_count - base_rd), 32'd2);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t6_reset_outputs", {16'd0, fifo_rd, out_valid, out_data, busy, done, words_left}, 32'd0);
    @(negedge clk);
    #1;
    check("t6_no_pop_in_reset", 32'(rd_count - base_rd), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("t6_idle_after", {30'd0, busy, out_valid}, 32'd0);
    base_rd   = rd_count;
    base_xfer = xfer_count;
    out_ready = 1'b1;
    start     = 1'b1;
    len       = 4'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t6", 20);
    check("t6_next_word", {24'd0, xfer_log[base_xfer]}, {24'd0, 8'd25});
    check("t6_one_pop", 32'(rd_count - base_rd), 32'd1);
    check("never_pop_empty", 32'(empty_pop_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

  // Global time guard so the bench always ends by itself.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
